// File: rtl/univ_reg_pkg.sv
// Shared types for the universal register: 3-bit mode encodings.
// Optional saturation of INC/DEC is selected with UNIV_REG_SAT_EN.
package univ_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_t;

endpackage

// File: rtl/univ_reg_next.sv
// Next-state function of the universal register (pure combinational).
// `define UNIV_REG_SAT_EN makes INC/DEC saturate at the range ends.
module univ_reg_next
  import univ_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] data_q,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in,
  input  logic             ser_q,
  input  logic             carry_q,
  output logic [WIDTH-1:0] data_d,
  output logic             ser_d,
  output logic             carry_d
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           lsb;
  logic           msb;

  assign sum  = {1'b0, data_q} + ONE;
  assign diff = {1'b0, data_q} - ONE;
  assign lsb  = data_q[0];
  assign msb  = data_q[WIDTH-1];

  always_comb begin
    data_d  = data_q;
    ser_d   = ser_q;
    carry_d = carry_q;
    unique case (mode)
      MODE_HOLD: ;
      MODE_LOAD: begin
        data_d  = data_in;
        carry_d = 1'b0;
      end
      MODE_SHL: begin
        data_d  = {data_q[WIDTH-2:0], ser_in};
        ser_d   = msb;
        carry_d = msb;
      end
      MODE_SHR: begin
        data_d  = {ser_in, data_q[WIDTH-1:1]};
        ser_d   = lsb;
        carry_d = lsb;
      end
      MODE_ROL: begin
        data_d  = {data_q[WIDTH-2:0], msb};
        ser_d   = msb;
        carry_d = msb;
      end
      MODE_ROR: begin
        data_d  = {lsb, data_q[WIDTH-1:1]};
        ser_d   = lsb;
        carry_d = lsb;
      end
      MODE_INC: begin
        {carry_d, data_d} = sum;
`ifdef UNIV_REG_SAT_EN
        if (sum[WIDTH]) data_d = data_q;
`endif
      end
      MODE_DEC: begin
        {carry_d, data_d} = diff;
`ifdef UNIV_REG_SAT_EN
        if (diff[WIDTH]) data_d = data_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_register.sv
// Universal register: load/shift/rotate/count with serial I/O and carry.
// Saturating INC/DEC when UNIV_REG_SAT_EN is defined.
module univ_register
  import univ_reg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_q, ser_d;
  logic             carry_q, carry_d;

  univ_reg_next #(.WIDTH(WIDTH)) u_next (
    .mode    (mode_t'(mode)),
    .data_q  (data_q),
    .data_in (data_in),
    .ser_in  (ser_in),
    .ser_q   (ser_q),
    .carry_q (carry_q),
    .data_d  (data_d),
    .ser_d   (ser_d),
    .carry_d (carry_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= RST_VAL;
      ser_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ser_q   <= ser_d;
      carry_q <= carry_d;
    end
  end

  assign data_out = data_q;
  assign ser_out  = ser_q;
  assign carry    = carry_q;
  assign zero     = (data_q == '0);

endmodule

// File: tb/tb_univ_register.sv
// Directed bench for univ_register: default-reset and 8'h3C-reset instances.
// Expected values are hand-computed; SAT variant via UNIV_REG_SAT_EN.
module tb_univ_register;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic [7:0] data_in;
  logic       ser_in;

  logic [7:0] d0, d1;
  logic       s0, s1, c0, c1, z0, z1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  univ_register #(.WIDTH(8), .RST_VAL(8'h00)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .data_in(data_in),
    .ser_in(ser_in), .data_out(d0), .ser_out(s0),
    .carry(c0), .zero(z0)
  );

  univ_register #(.WIDTH(8), .RST_VAL(8'h3C)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .data_in(data_in),
    .ser_in(ser_in), .data_out(d1), .ser_out(s1),
    .carry(c1), .zero(z1)
  );

  always @(posedge clk) begin
    if ($isunknown(mode) && !rst) begin
      errors++;
      $error("FAIL mode_x: observed %b required known", mode);
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step(logic [2:0] m, logic [7:0] din, logic si);
    mode    = m;
    data_in = din;
    ser_in  = si;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    mode    = 3'b001;
    data_in = 8'hFF;
    ser_in  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  d0, 8'h00);
    chk("rst_carry", c0, 1'b0);
    chk("rst_ser",   s0, 1'b0);
    chk("rst_zero",  z0, 1'b1);
    chk("rst_data1", d1, 8'h3C);
    chk("rst_zero1", z1, 1'b0);
    rst = 1'b0;

    step(3'b001, 8'hA5, 1'b0);
    chk("load_a5", d0, 8'hA5);
    chk("load_c",  c0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(3'b000, 8'h00, 1'b1);
      chk("hold_d", d0, 8'hA5);
      chk("hold_c", c0, 1'b0);
    end

    step(3'b001, 8'h81, 1'b0);
    step(3'b010, 8'h00, 1'b0);
    chk("shl_d", d0, 8'h02);
    chk("shl_s", s0, 1'b1);
    chk("shl_c", c0, 1'b1);
    step(3'b011, 8'h00, 1'b1);
    chk("shr_d", d0, 8'h81);
    chk("shr_s", s0, 1'b0);
    chk("shr_c", c0, 1'b0);

    step(3'b001, 8'h01, 1'b1);
    step(3'b101, 8'h00, 1'b0);
    chk("ror_d", d0, 8'h80);
    chk("ror_c", c0, 1'b1);
    chk("ror_s", s0, 1'b1);
    step(3'b100, 8'h00, 1'b0);
    chk("rol1_d", d0, 8'h01);
    chk("rol1_c", c0, 1'b1);
    step(3'b100, 8'h00, 1'b1);
    chk("rol2_d", d0, 8'h02);
    chk("rol2_c", c0, 1'b0);
    chk("rol2_s", s0, 1'b0);

    step(3'b001, 8'h03, 1'b0);
    step(3'b101, 8'h00, 1'b0);
    chk("ror3_d", d0, 8'h81);
    step(3'b110, 8'h00, 1'b0);
    chk("inc_d",    d0, 8'h82);
    chk("inc_c",    c0, 1'b0);
    chk("inc_sero", s0, 1'b1);
    step(3'b111, 8'h00, 1'b0);
    chk("dec_d",    d0, 8'h81);
    chk("dec_sero", s0, 1'b1);

    step(3'b001, 8'hFE, 1'b0);
    step(3'b110, 8'h00, 1'b0);
    chk("inc_ff_d", d0, 8'hFF);
    chk("inc_ff_c", c0, 1'b0);
    step(3'b110, 8'h00, 1'b0);
`ifdef UNIV_REG_SAT_EN
    chk("inc_sat_d", d0, 8'hFF);
    chk("inc_sat_c", c0, 1'b1);
    chk("inc_sat_z", z0, 1'b0);
    step(3'b111, 8'h00, 1'b0);
    chk("dec_fe_d", d0, 8'hFE);
    chk("dec_fe_c", c0, 1'b0);
    step(3'b001, 8'h00, 1'b0);
    step(3'b111, 8'h00, 1'b0);
    chk("dec_sat_d", d0, 8'h00);
    chk("dec_sat_c", c0, 1'b1);
`else
    chk("inc_wrap_d", d0, 8'h00);
    chk("inc_wrap_c", c0, 1'b1);
    chk("inc_wrap_z", z0, 1'b1);
    step(3'b111, 8'h00, 1'b0);
    chk("dec_wrap_d", d0, 8'hFF);
    chk("dec_wrap_c", c0, 1'b1);
    step(3'b111, 8'h00, 1'b0);
    chk("dec_fe_d", d0, 8'hFE);
    chk("dec_fe_c", c0, 1'b0);
`endif
    step(3'b001, 8'h05, 1'b0);
    step(3'b111, 8'h00, 1'b0);
    chk("dec_5_d", d0, 8'h04);
    chk("dec_5_c", c0, 1'b0);

    step(3'b001, 8'h10, 1'b0);
    step(3'b110, 8'h00, 1'b0);
    chk("cnt1_d", d0, 8'h11);
    step(3'b110, 8'h00, 1'b0);
    chk("cnt2_d", d0, 8'h12);
    rst = 1'b1;
    step(3'b110, 8'h00, 1'b0);
    chk("mid_rst_d0", d0, 8'h00);
    chk("mid_rst_d1", d1, 8'h3C);
    chk("mid_rst_z0", z0, 1'b1);
    rst = 1'b0;
    step(3'b110, 8'h00, 1'b0);
    chk("resume_d0", d0, 8'h01);
    chk("resume_d1", d1, 8'h3D);
    chk("resume_c1", c1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
